// File: rtl/shift_pkg.sv
// Shared definitions for the Thumb shift/MOV decode-issue stage: shift-type codes,
// opcode field constants, FSM state encoding and the immediate shift-amount helper.
package shift_pkg;

  localparam logic [1:0] STYPE_LSL = 2'b00;
  localparam logic [1:0] STYPE_LSR = 2'b01;
  localparam logic [1:0] STYPE_ASR = 2'b10;

  localparam logic [2:0] OP_SHIFT_IMM = 3'b000;  // inst[15:13], inst[12:11] = shift type
  localparam logic [4:0] OP_MOV_IMM   = 5'b00100;
  localparam logic [5:0] OP_DP        = 6'b010000;
  localparam logic [3:0] DP_LSL       = 4'b0010;
  localparam logic [3:0] DP_LSR       = 4'b0011;
  localparam logic [3:0] DP_ASR       = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_ISSUE  = 2'b10,
    ST_WB     = 2'b11
  } state_t;

  // LSR/ASR encode a shift of 32 as imm5 == 0; LSL #0 is a plain move.
  function automatic logic [7:0] imm_amount(input logic [1:0] stype, input logic [4:0] imm5);
    if (stype != STYPE_LSL && imm5 == 5'd0) return 8'd32;
    return {3'b000, imm5};
  endfunction

endpackage

// File: rtl/shift_decode_issue_if.sv
// Instruction handshake plus the shift-unit operand/result bus; slave = decode stage,
// master = instruction producer together with the shift unit.
interface shift_decode_issue_if #(parameter int REG_W = 32);

  logic [15:0]      inst;
  logic             inst_valid;
  logic             inst_ready;
  logic             en_inst;
  logic             S;
  logic [REG_W-1:0] Rm;
  logic [7:0]       operand2;
  logic [1:0]       stype;
  logic             carry_in;
  logic             zero_in;
  logic             neg_in;
  logic [REG_W-1:0] Rd;
  logic             carry_out;
  logic             zero_out;
  logic             neg_out;

  modport slave (
    input  inst, inst_valid, Rd, carry_out, zero_out, neg_out,
    output inst_ready, en_inst, S, Rm, operand2, stype, carry_in, zero_in, neg_in
  );

  modport master (
    output inst, inst_valid, Rd, carry_out, zero_out, neg_out,
    input  inst_ready, en_inst, S, Rm, operand2, stype, carry_in, zero_in, neg_in
  );

endinterface

// File: rtl/shift_regfile.sv
// Low register file r0-r7: combinational operand and debug reads, one synchronous write, async clear.
// SHIFT_DEC_REGFORM_EN adds a second operand read port for the register-specified shift amount.
module shift_regfile #(
  parameter int REG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       rd_addr,
  output logic [REG_W-1:0] rd_data,
`ifdef SHIFT_DEC_REGFORM_EN
  input  logic [2:0]       amt_addr,
  output logic [REG_W-1:0] amt_data,
`endif
  input  logic [2:0]       dbg_addr,
  output logic [REG_W-1:0] dbg_data,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [REG_W-1:0] wr_data
);

  logic [REG_W-1:0] regs [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data  = regs[rd_addr];
  assign dbg_data = regs[dbg_addr];
`ifdef SHIFT_DEC_REGFORM_EN
  assign amt_data = regs[amt_addr];
`endif

endmodule

// File: rtl/shift_decode_issue.sv
// Decode/issue stage for the MOV/shift unit: accept -> done in 2+ISSUE_HOLD cycles, one instruction
// outstanding, inst_ready only in IDLE. SHIFT_DEC_REGFORM_EN enables LSLS/LSRS/ASRS Rdn,Rm.
module shift_decode_issue
  import shift_pkg::*;
#(
  parameter int REG_W      = 32,
  parameter int ISSUE_HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_decode_issue_if.slave  bus,
  output logic                 done,
  output logic                 illegal,
  input  logic [2:0]           dbg_addr,
  output logic [REG_W-1:0]     dbg_data
);

  localparam int CNT_W = (ISSUE_HOLD > 1) ? $clog2(ISSUE_HOLD) : 1;

  state_t           state, state_nxt;
  logic [15:0]      inst_q;
  logic [CNT_W-1:0] hold_cnt;
  logic [REG_W-1:0] rm_q;
  logic [7:0]       amt_q;
  logic [1:0]       stype_q;
  logic [2:0]       dest_q;
  logic             n_q, z_q, c_q;

  logic             dec_legal;
  logic [1:0]       dec_stype;
  logic [7:0]       dec_amt;
  logic [2:0]       dec_src;
  logic [2:0]       dec_dest;
  logic             dec_imm8;
  logic [REG_W-1:0] dec_rm;
  logic [7:0]       dec_op2;
  logic [REG_W-1:0] rf_rd_data;
`ifdef SHIFT_DEC_REGFORM_EN
  logic             dec_reg_amt;
  logic [2:0]       dec_amt_src;
  logic [REG_W-1:0] rf_amt_data;
`endif

  // Decode works on the latched instruction so the producer may change inst after acceptance.
  always_comb begin
    dec_legal = 1'b0;
    dec_stype = STYPE_LSL;
    dec_amt   = '0;
    dec_src   = inst_q[5:3];
    dec_dest  = inst_q[2:0];
    dec_imm8  = 1'b0;
`ifdef SHIFT_DEC_REGFORM_EN
    dec_reg_amt = 1'b0;
    dec_amt_src = inst_q[5:3];
`endif
    if (inst_q[15:13] == OP_SHIFT_IMM && inst_q[12:11] != 2'b11) begin
      dec_legal = 1'b1;
      dec_stype = inst_q[12:11];
      dec_amt   = imm_amount(inst_q[12:11], inst_q[10:6]);
    end else if (inst_q[15:11] == OP_MOV_IMM) begin
      dec_legal = 1'b1;
      dec_imm8  = 1'b1;
      dec_dest  = inst_q[10:8];
    end
`ifdef SHIFT_DEC_REGFORM_EN
    else if (inst_q[15:10] == OP_DP &&
             (inst_q[9:6] == DP_LSL || inst_q[9:6] == DP_LSR || inst_q[9:6] == DP_ASR)) begin
      dec_legal   = 1'b1;
      dec_reg_amt = 1'b1;
      dec_src     = inst_q[2:0];
      dec_dest    = inst_q[2:0];
      dec_stype   = (inst_q[9:6] == DP_LSL) ? STYPE_LSL :
                    (inst_q[9:6] == DP_LSR) ? STYPE_LSR : STYPE_ASR;
    end
`endif
  end

  assign dec_rm = dec_imm8 ? {{(REG_W-8){1'b0}}, inst_q[7:0]} : rf_rd_data;
`ifdef SHIFT_DEC_REGFORM_EN
  assign dec_op2 = !dec_reg_amt            ? dec_amt :
                   (|rf_amt_data[REG_W-1:8]) ? 8'hFF  : rf_amt_data[7:0];
`else
  assign dec_op2 = dec_amt;
`endif

  always_comb begin
    state_nxt      = state;
    bus.inst_ready = 1'b0;
    bus.en_inst    = 1'b0;
    bus.S          = 1'b0;
    done           = 1'b0;
    illegal        = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.inst_ready = 1'b1;
        if (bus.inst_valid) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        illegal   = !dec_legal;
        state_nxt = dec_legal ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: begin
        bus.en_inst = 1'b1;
        bus.S       = 1'b1;
        if (hold_cnt == CNT_W'(ISSUE_HOLD - 1)) state_nxt = ST_WB;
      end
      ST_WB: begin
        bus.en_inst = 1'b1;
        bus.S       = 1'b1;
        done        = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      inst_q   <= '0;
      hold_cnt <= '0;
      rm_q     <= '0;
      amt_q    <= '0;
      stype_q  <= STYPE_LSL;
      dest_q   <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == ST_ISSUE) ? hold_cnt + 1'b1 : '0;
      if (state == ST_IDLE && bus.inst_valid) inst_q <= bus.inst;
      // Operands are frozen here so they stay stable for the whole en_inst window.
      if (state == ST_DECODE && dec_legal) begin
        rm_q    <= dec_rm;
        amt_q   <= dec_op2;
        stype_q <= dec_stype;
        dest_q  <= dec_dest;
      end
      if (state == ST_WB) begin
        n_q <= bus.neg_out;
        z_q <= bus.zero_out;
        c_q <= bus.carry_out;
      end
    end
  end

  assign bus.Rm       = rm_q;
  assign bus.operand2 = amt_q;
  assign bus.stype    = stype_q;
  assign bus.carry_in = c_q;
  assign bus.zero_in  = z_q;
  assign bus.neg_in   = n_q;

  shift_regfile #(.REG_W(REG_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (dec_src),
    .rd_data  (rf_rd_data),
`ifdef SHIFT_DEC_REGFORM_EN
    .amt_addr (dec_amt_src),
    .amt_data (rf_amt_data),
`endif
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_en    (state == ST_WB),
    .wr_addr  (dest_q),
    .wr_data  (bus.Rd)
  );

endmodule

// File: tb/tb_shift_decode_issue.sv
// Bench for shift_decode_issue: behavioural shift unit, vector table with a scoreboard queue,
// plus back-to-back issue and reset-during-issue sequences.
module tb_shift_decode_issue;
  import shift_pkg::*;

  typedef struct packed {
    logic [15:0] inst;
    logic        ill;
    logic [7:0]  op2;
    logic [1:0]  st;
    logic [2:0]  dest;
    logic [31:0] val;
    logic        n;
    logic        z;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        done, illegal;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] u_r;
  logic        u_c;

  int   checks = 0;
  int   passed = 0;
  int   done_cnt = 0;
  int   b2b_viol = 0;
  logic prev_done = 1'b0;
  vec_t vecs[16];
  vec_t sb[$];

  always #5 clk = ~clk;

  shift_decode_issue_if #(.REG_W(32)) bus();

  shift_decode_issue #(.REG_W(32), .ISSUE_HOLD(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .done     (done),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Reference shift unit: ARM LSL/LSR/ASR semantics, carry passes through for a zero amount.
  function automatic logic [32:0] unit_shift(input logic [31:0] v, input logic [7:0] n,
                                             input logic [1:0] st, input logic cin);
    logic [31:0] r;
    logic        c;
    int          k;
    r = v;
    c = cin;
    k = int'(n);
    if (k != 0) begin
      if (st == STYPE_LSL) begin
        if (k < 32) begin r = v << k; c = v[32-k]; end
        else begin r = '0; c = (k == 32) ? v[0] : 1'b0; end
      end else if (st == STYPE_LSR) begin
        if (k < 32) begin r = v >> k; c = v[k-1]; end
        else begin r = '0; c = (k == 32) ? v[31] : 1'b0; end
      end else begin
        if (k < 32) begin r = 32'($signed(v) >>> k); c = v[k-1]; end
        else begin r = {32{v[31]}}; c = v[31]; end
      end
    end
    return {c, r};
  endfunction

  always_comb begin
    {u_c, u_r} = 33'd0;
    {u_c, u_r} = unit_shift(bus.Rm, bus.operand2, bus.stype, bus.carry_in);
  end

  assign bus.Rd        = u_r;
  assign bus.carry_out = u_c;
  assign bus.zero_out  = (u_r == 32'd0);
  assign bus.neg_out   = u_r[31];

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if ((prev_done && bus.en_inst) || (bus.inst_ready && bus.en_inst)) b2b_viol <= b2b_viol + 1;
    prev_done <= done;
  end

  function automatic logic [15:0] enc_sh(input logic [1:0] op, input logic [4:0] imm5,
                                         input logic [2:0] rm, input logic [2:0] rd);
    return {3'b000, op, imm5, rm, rd};
  endfunction

  function automatic logic [15:0] enc_mov(input logic [2:0] rd, input logic [7:0] imm8);
    return {5'b00100, rd, imm8};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic wait_ready(input string name);
    int cyc = 0;
    while (!bus.inst_ready && cyc < 20) begin @(negedge clk); cyc++; end
    if (!bus.inst_ready) check({name, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    logic        got_en;
    logic [7:0]  op2_seen;
    logic [1:0]  st_seen;
    logic        s_seen;
    vec_t        e;
    string       nm;
    nm = $sformatf("v%0d", idx);
    bus.inst       = v.inst;
    bus.inst_valid = 1'b1;
    wait_ready(nm);
    sb.push_back(v);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    cyc      = 1;
    got_en   = 1'b0;
    op2_seen = '0;
    st_seen  = '0;
    s_seen   = 1'b0;
    while (!done && !illegal && cyc < 20) begin
      if (bus.en_inst && !got_en) begin
        got_en = 1'b1; op2_seen = bus.operand2; st_seen = bus.stype; s_seen = bus.S;
      end
      @(negedge clk);
      cyc++;
    end
    if (bus.en_inst && !got_en) begin
      got_en = 1'b1; op2_seen = bus.operand2; st_seen = bus.stype; s_seen = bus.S;
    end
    if (sb.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({nm, "_outcome"}, {30'd0, done, illegal}, e.ill ? 32'd1 : 32'd2);
    if (!e.ill) begin
      check({nm, "_latency"}, cyc, 32'd3);
      check({nm, "_op2"}, {24'd0, op2_seen}, {24'd0, e.op2});
      check({nm, "_stype_S"}, {29'd0, st_seen, s_seen}, {29'd0, e.st, 1'b1});
    end
    @(negedge clk);
    dbg_addr = e.dest;
    #1;
    check({nm, "_reg"}, dbg_data, e.val);
    check({nm, "_nzc"}, {29'd0, bus.neg_in, bus.zero_in, bus.carry_in}, {29'd0, e.n, e.z, e.c});
  endtask

  initial begin
    logic [15:0] b2b[3];
    logic [31:0] reg_or;
    int          cyc;
    int          start;

    vecs[0]  = '{enc_mov(3'd1, 8'd1),               1'b0, 8'd0,  STYPE_LSL, 3'd1, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{enc_sh(STYPE_LSL, 5'd31, 3'd1, 3'd1), 1'b0, 8'd31, STYPE_LSL, 3'd1, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{enc_sh(STYPE_LSL, 5'd1, 3'd1, 3'd2),  1'b0, 8'd1,  STYPE_LSL, 3'd2, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{enc_sh(STYPE_ASR, 5'd0, 3'd1, 3'd3),  1'b0, 8'd32, STYPE_ASR, 3'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{enc_sh(STYPE_LSR, 5'd4, 3'd3, 3'd4),  1'b0, 8'd4,  STYPE_LSR, 3'd4, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{enc_sh(STYPE_LSR, 5'd0, 3'd3, 3'd5),  1'b0, 8'd32, STYPE_LSR, 3'd5, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{enc_mov(3'd0, 8'h00),              1'b0, 8'd0,  STYPE_LSL, 3'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{enc_mov(3'd4, 8'hFF),              1'b0, 8'd0,  STYPE_LSL, 3'd4, 32'h0000_00FF, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{16'hFFFF,                          1'b1, 8'd0,  STYPE_LSL, 3'd4, 32'h0000_00FF, 1'b0, 1'b0, 1'b1};
`ifdef SHIFT_DEC_REGFORM_EN
    vecs[9]  = '{16'h4088,                          1'b0, 8'd255, STYPE_LSL, 3'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
`else
    vecs[9]  = '{16'h4088,                          1'b1, 8'd0,  STYPE_LSL, 3'd4, 32'h0000_00FF, 1'b0, 1'b0, 1'b1};
`endif
    vecs[10] = '{enc_sh(STYPE_ASR, 5'd3, 3'd4, 3'd6),  1'b0, 8'd3,  STYPE_ASR, 3'd6, 32'h0000_001F, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{enc_sh(STYPE_LSL, 5'd28, 3'd4, 3'd7), 1'b0, 8'd28, STYPE_LSL, 3'd7, 32'hF000_0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{enc_sh(STYPE_LSL, 5'd4, 3'd7, 3'd7),  1'b0, 8'd4,  STYPE_LSL, 3'd7, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{enc_mov(3'd2, 8'd2),               1'b0, 8'd0,  STYPE_LSL, 3'd2, 32'h0000_0002, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{enc_sh(STYPE_LSR, 5'd1, 3'd2, 3'd2),  1'b0, 8'd1,  STYPE_LSR, 3'd2, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{16'h1C00,                          1'b1, 8'd0,  STYPE_LSL, 3'd2, 32'h0000_0001, 1'b0, 1'b0, 1'b0};

    rst            = 1'b1;
    bus.inst       = '0;
    bus.inst_valid = 1'b0;
    dbg_addr       = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_ready_en_S", {29'd0, bus.inst_ready, bus.en_inst, bus.S}, 32'd4);
    check("rst_done_illegal", {30'd0, done, illegal}, 32'd0);
    check("rst_Rm", bus.Rm, 32'd0);
    check("rst_op2_stype", {22'd0, bus.operand2, bus.stype}, 32'd0);
    check("rst_nzc", {29'd0, bus.neg_in, bus.zero_in, bus.carry_in}, 32'd0);
    check("rst_r0", dbg_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Back-to-back: inst_valid stays high across three instructions.
    b2b[0] = enc_mov(3'd0, 8'd5);
    b2b[1] = enc_sh(STYPE_LSL, 5'd2, 3'd0, 3'd1);
    b2b[2] = enc_sh(STYPE_LSR, 5'd1, 3'd1, 3'd2);
    start  = done_cnt;
    bus.inst_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.inst = b2b[k];
      wait_ready("b2b");
      @(negedge clk);
      check($sformatf("b2b%0d_ready_low", k), {31'd0, bus.inst_ready}, 32'd0);
    end
    bus.inst_valid = 1'b0;
    cyc = 0;
    while (done_cnt < start + 3 && cyc < 40) begin @(negedge clk); cyc++; end
    @(negedge clk);
    check("b2b_done_count", done_cnt - start, 32'd3);
    check("b2b_en_gap_viol", b2b_viol, 32'd0);
    dbg_addr = 3'd0; #1; check("b2b_r0", dbg_data, 32'd5);
    dbg_addr = 3'd1; #1; check("b2b_r1", dbg_data, 32'd20);
    dbg_addr = 3'd2; #1; check("b2b_r2", dbg_data, 32'd10);

    // Reset while the instruction is in ISSUE.
    bus.inst       = enc_mov(3'd5, 8'd9);
    bus.inst_valid = 1'b1;
    wait_ready("rstmid");
    @(negedge clk);
    bus.inst_valid = 1'b0;
    cyc = 0;
    while (!bus.en_inst && cyc < 10) begin @(negedge clk); cyc++; end
    check("rstmid_reached_issue", {31'd0, bus.en_inst}, 32'd1);
    start = done_cnt;
    rst = 1'b1;
    #1;
    check("rstmid_en_done", {30'd0, bus.en_inst, done}, 32'd0);
    reg_or = '0;
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      reg_or = reg_or | dbg_data;
    end
    check("rstmid_regs_clear", reg_or, 32'd0);
    check("rstmid_nzc", {29'd0, bus.neg_in, bus.zero_in, bus.carry_in}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_no_done", done_cnt - start, 32'd0);
    run_vec('{enc_mov(3'd5, 8'd9), 1'b0, 8'd0, STYPE_LSL, 3'd5, 32'd9, 1'b0, 1'b0, 1'b0}, 99);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
